// File: rtl/edge_hysteresis_if.sv
// Pixel stream, threshold and edge-statistics signals of the hysteresis stage.
interface edge_hysteresis_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             i_vsync;
    logic             i_hsync;
    logic             i_de;
    logic [WIDTH-1:0] i_data;
    logic [WIDTH-1:0] i_th_high;
    logic [WIDTH-1:0] i_th_low;
    logic             o_vsync;
    logic             o_hsync;
    logic             o_de;
    logic [WIDTH-1:0] o_data;
    logic [CNT_W-1:0] o_edge_cnt;
    logic             o_cnt_valid;

    // Upstream / testbench side
    modport master (
        output i_vsync, i_hsync, i_de, i_data, i_th_high, i_th_low,
        input  o_vsync, o_hsync, o_de, o_data, o_edge_cnt, o_cnt_valid
    );

    // Hysteresis block side
    modport slave (
        input  i_vsync, i_hsync, i_de, i_data, i_th_high, i_th_low,
        output o_vsync, o_hsync, o_de, o_data, o_edge_cnt, o_cnt_valid
    );
endinterface

// File: rtl/edge_hysteresis.sv
// Canny-style hysteresis thresholding over a 3x3 class window, with
// per-frame edge-pixel statistics.
module edge_hysteresis #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned H_RES = 176,
    parameter int unsigned V_RES = 144,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    edge_hysteresis_if.slave  bus
);
    localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_WEAK   = 2'd1;
    localparam logic [1:0] CLS_STRONG = 2'd2;

    logic             vs_d;
    logic             vs_rise_c;
    logic [WIDTH-1:0] th_high;
    logic [WIDTH-1:0] th_low;
    logic [WIDTH-1:0] th_low_eff_c;
    logic [1:0]       cls_new_c;

    logic [1:0]       lb_mid [H_RES];
    logic [1:0]       lb_top [H_RES];

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_col_c;
    logic [1:0]       win [3][3];
    logic [COL_W-1:0] win_col;
    logic [ROW_W-1:0] win_row;

    logic [COL_W-1:0] cen_col_c;
    logic [ROW_W-1:0] cen_row_c;
    logic             top_ok_c;
    logic             left_ok_c;
    logic             right_ok_c;
    logic             strong_nb_c;
    logic             edge_c;
    logic             dec_q;

    logic [2:0]       sync_d1;
    logic [2:0]       sync_d2;

    logic             ovs_prev;
    logic             ovs_rise_c;
    logic             edge_now_c;
    logic [CNT_W-1:0] edge_cnt;

    assign vs_rise_c  = bus.i_vsync & ~vs_d;
    assign last_col_c = (col == COL_W'(H_RES - 1));

    // Threshold shadows: latched only at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d    <= 1'b0;
            th_high <= '1;
            th_low  <= '1;
        end else begin
            vs_d <= bus.i_vsync;
            if (vs_rise_c) begin
                th_high <= bus.i_th_high;
                th_low  <= bus.i_th_low;
            end
        end
    end

    // Strong / weak / none classification of the incoming pixel
    always_comb begin
        th_low_eff_c = (th_low < th_high) ? th_low : th_high;
        cls_new_c    = CLS_NONE;
        if (bus.i_data >= th_high) begin
            cls_new_c = CLS_STRONG;
        end else if (bus.i_data >= th_low_eff_c) begin
            cls_new_c = CLS_WEAK;
        end
    end

    // Two line buffers of classes: lb_mid holds row-1, lb_top holds row-2
    always_ff @(posedge clk) begin
        if (bus.i_de) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= cls_new_c;
        end
    end

    // Raster position counters and 3x3 window shift (stage 1)
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            win_col <= '0;
            win_row <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= CLS_NONE;
                end
            end
        end else begin
            if (bus.i_de) begin
                col     <= last_col_c ? '0 : col + COL_W'(1);
                win_col <= col;
                win_row <= row;
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb_top[col];
                win[1][2] <= lb_mid[col];
                win[2][2] <= cls_new_c;
            end
            if (vs_rise_c) begin
                row <= '0;
            end else if (bus.i_de && last_col_c && (row != ROW_W'(V_RES - 1))) begin
                row <= row + ROW_W'(1);
            end
        end
    end

    // Hysteresis decision on the window centre, neighbours outside the frame masked
    always_comb begin
        cen_col_c   = win_col - COL_W'(1);
        cen_row_c   = win_row - ROW_W'(1);
        top_ok_c    = (cen_row_c != '0);
        left_ok_c   = (cen_col_c != '0);
        right_ok_c  = (cen_col_c != COL_W'(H_RES - 1));
        strong_nb_c = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!((r == 1) && (c == 1)) && (win[r][c] == CLS_STRONG) &&
                    ((r != 0) || top_ok_c) && ((c != 0) || left_ok_c) &&
                    ((c != 2) || right_ok_c)) begin
                    strong_nb_c = 1'b1;
                end
            end
        end
        edge_c = 1'b0;
        if ((win_row != '0) && (win_col != '0)) begin
            edge_c = (win[1][1] == CLS_STRONG) ||
                     ((win[1][1] == CLS_WEAK) && strong_nb_c);
        end
    end

    // Decision register (stage 2) and output register (stage 3), sync delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q       <= 1'b0;
            sync_d1     <= '0;
            sync_d2     <= '0;
            bus.o_data  <= '0;
            bus.o_vsync <= 1'b0;
            bus.o_hsync <= 1'b0;
            bus.o_de    <= 1'b0;
        end else begin
            dec_q       <= edge_c;
            sync_d1     <= {bus.i_vsync, bus.i_hsync, bus.i_de};
            sync_d2     <= sync_d1;
            bus.o_data  <= dec_q ? {WIDTH{1'b1}} : '0;
            bus.o_vsync <= sync_d2[2];
            bus.o_hsync <= sync_d2[1];
            bus.o_de    <= sync_d2[0];
        end
    end

    assign ovs_rise_c = bus.o_vsync & ~ovs_prev;
    assign edge_now_c = bus.o_de & (bus.o_data != '0);

    // Per-frame edge counter; a same-cycle edge pixel belongs to the new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            ovs_prev        <= 1'b0;
            edge_cnt        <= '0;
            bus.o_edge_cnt  <= '0;
            bus.o_cnt_valid <= 1'b0;
        end else begin
            ovs_prev <= bus.o_vsync;
            if (ovs_rise_c) begin
                bus.o_edge_cnt  <= edge_cnt;
                bus.o_cnt_valid <= 1'b1;
                edge_cnt        <= edge_now_c ? CNT_W'(1) : '0;
            end else begin
                bus.o_cnt_valid <= 1'b0;
                if (edge_now_c && (edge_cnt != '1)) begin
                    edge_cnt <= edge_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_edge_hysteresis.sv
// Randomised frames checked against a frame-level hysteresis reference model.
module tb_edge_hysteresis;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned H     = 16;
    localparam int unsigned V     = 12;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    edge_hysteresis_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    edge_hysteresis #(
        .WIDTH(WIDTH), .H_RES(H), .V_RES(V), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         total;
    int         bad;
    logic [7:0] pix [V][H];
    bit         exp_q [$];
    int         cnt_q [$];
    logic [2:0] h [5];      // {vsync,hsync,de} input history, h[0] newest

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int cls_of(input int v, input int hi, input int lo);
        int le;
        le = (lo < hi) ? lo : hi;
        if (v >= hi) return 2;
        if (v >= le) return 1;
        return 0;
    endfunction

    // Expected output for the pixel arriving at (r,c): decision on centre (r-1,c-1)
    function automatic bit model_edge(input int r, input int c, input int hi, input int lo);
        int cr, cc, k, y, x;
        if (r == 0 || c == 0) return 1'b0;
        cr = r - 1;
        cc = c - 1;
        k  = cls_of(int'(pix[cr][cc]), hi, lo);
        if (k == 2) return 1'b1;
        if (k == 0) return 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                y = cr + dy;
                x = cc + dx;
                if (!(dy == 0 && dx == 0) && y >= 0 && y < int'(V) && x >= 0 && x < int'(H)) begin
                    if (cls_of(int'(pix[y][x]), hi, lo) == 2) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // One clock: record inputs, advance, check every output against the model
    task automatic cycle();
        bit exp_valid;
        bit e;
        int c;
        for (int k = 4; k > 0; k--) h[k] = h[k-1];
        h[0] = {bus.i_vsync, bus.i_hsync, bus.i_de};
        @(posedge clk);
        #1;
        if (rst) begin
            for (int k = 0; k < 5; k++) h[k] = 3'b000;
            exp_q.delete();
            cnt_q.delete();
            cnt_q.push_back(0);
            chk("reset_outs", {bus.o_vsync, bus.o_hsync, bus.o_de, bus.o_cnt_valid,
                               bus.o_data, bus.o_edge_cnt}, 32'd0);
            return;
        end
        chk("sync_delay", {29'd0, bus.o_vsync, bus.o_hsync, bus.o_de}, {29'd0, h[2]});
        exp_valid = h[3][2] & ~h[4][2];
        chk("cnt_valid", {31'd0, bus.o_cnt_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            if (cnt_q.size() == 0) begin
                chk("cnt_underflow", 32'd1, 32'd0);
            end else begin
                c = cnt_q.pop_front();
                chk("edge_cnt", {16'd0, bus.o_edge_cnt}, 32'(c));
            end
        end
        if (h[2][0]) begin
            if (exp_q.size() == 0) begin
                chk("pix_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("o_data", {24'd0, bus.o_data}, e ? 32'hFF : 32'h0);
            end
        end
    endtask

    task automatic idle(input int n);
        bus.i_de = 1'b0;
        bus.i_hsync = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic vsync_pulse(input int hi, input int lo);
        bus.i_th_high = 8'(hi);
        bus.i_th_low  = 8'(lo);
        bus.i_de = 1'b0;
        bus.i_hsync = 1'b0;
        bus.i_vsync = 1'b1;
        cycle();
        cycle();
        bus.i_vsync = 1'b0;
        cycle();
    endtask

    // Drive one frame with random de gaps and junk thresholds after frame start
    task automatic run_frame(input int hi, input int lo, input int exp_cnt);
        int n;
        bit e;
        n = 0;
        for (int r = 0; r < int'(V); r++) begin
            for (int c = 0; c < int'(H); c++) begin
                e = model_edge(r, c, hi, lo);
                exp_q.push_back(e);
                n += int'(e);
            end
        end
        cnt_q.push_back((exp_cnt >= 0) ? exp_cnt : n);
        vsync_pulse(hi, lo);
        for (int r = 0; r < int'(V); r++) begin
            for (int c = 0; c < int'(H); c++) begin
                bus.i_th_high = 8'($urandom);
                bus.i_th_low  = 8'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    bus.i_de   = 1'b0;
                    bus.i_data = 8'($urandom);
                    bus.i_hsync = 1'($urandom_range(0, 1));
                    cycle();
                end
                bus.i_hsync = 1'b0;
                bus.i_de   = 1'b1;
                bus.i_data = pix[r][c];
                cycle();
            end
            bus.i_de = 1'b0;
            bus.i_hsync = 1'b1;
            cycle();
            bus.i_hsync = 1'b0;
            cycle();
        end
        idle(3);
    endtask

    task automatic flush_frame();
        cnt_q.push_back(0);
        vsync_pulse(100, 50);
        idle(4);
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < int'(V); r++)
            for (int c = 0; c < int'(H); c++)
                pix[r][c] = 8'(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_vsync = 1'b0;
        bus.i_hsync = 1'b0;
        bus.i_de    = 1'b0;
        bus.i_data  = '0;
        bus.i_th_high = '0;
        bus.i_th_low  = '0;
        for (int k = 0; k < 5; k++) h[k] = 3'b000;
        cnt_q.push_back(0);

        cycle();
        cycle();
        rst = 1'b0;
        idle(3);

        // Uniform strong frame
        fill(200);
        run_frame(100, 50, int'((H - 1) * (V - 1)));

        // Weak field with one strong pixel
        fill(60);
        pix[5][5] = 8'd120;
        run_frame(100, 50, 9);

        // Isolated weak pixel
        fill(0);
        pix[6][7] = 8'd70;
        run_frame(100, 50, 0);

        // Strong at right edge must not reach the next row's column 0
        fill(0);
        pix[5][H-1] = 8'd200;
        pix[6][0]   = 8'd70;
        run_frame(100, 50, 0);

        // Low above high: only >= high is an edge
        for (int r = 0; r < int'(V); r++)
            for (int c = 0; c < int'(H); c++)
                pix[r][c] = 8'($urandom_range(60, 140));
        run_frame(100, 150, -1);

        // Random frames with random thresholds
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < int'(V); r++)
                for (int c = 0; c < int'(H); c++)
                    pix[r][c] = 8'($urandom);
            run_frame(int'($urandom_range(60, 220)), int'($urandom_range(0, 255)), -1);
        end
        flush_frame();

        // Reset asserted in the middle of a line
        vsync_pulse(100, 50);
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(1'b0);
            bus.i_de   = 1'b1;
            bus.i_data = 8'd200;
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.i_de = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_rst_data", {24'd0, bus.o_data}, 32'd0);
        end

        // Recovery frame after reset
        fill(200);
        run_frame(100, 50, int'((H - 1) * (V - 1)));
        flush_frame();

        chk("drain_pix", 32'(exp_q.size()), 32'd0);
        chk("drain_cnt", 32'(cnt_q.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_hysteresis.md
EDGE_HYSTERESIS -- requirements
Module: edge_hysteresis

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pixel bit width of input and output data.
REQ-002 SHALL have parameter H_RES, default 176, active pixels per line.
REQ-003 SHALL have parameter V_RES, default 144, active lines per frame.
REQ-004 SHALL have parameter CNT_W, default 16, width of the per-frame edge counter.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_vsync / i_hsync / i_de  input  1 each  sync and data-enable from the upstream Sobel stage.
REQ-008 i_data  input  WIDTH  gradient magnitude from Sobel.
REQ-009 i_th_high / i_th_low  input  WIDTH each  strong and weak thresholds.
REQ-010 o_vsync / o_hsync / o_de  output  1 each  syncs and enable delayed to match o_data.
REQ-011 o_data  output  WIDTH  binary edge map: all ones = edge, 0 = no edge.
REQ-012 o_edge_cnt  output  CNT_W  edge-pixel count of the last completed frame.
REQ-013 o_cnt_valid  output  1  one-cycle pulse when o_edge_cnt updates.

Function
REQ-014 Threshold shadow registers SHALL load i_th_high/i_th_low only on the i_vsync rising edge; mid-frame changes have no effect.
REQ-015 Effective low SHALL equal min(shadow_low, shadow_high).
REQ-016 Classification SHALL be 2-bit: STRONG if i_data >= high; WEAK if low <= i_data < high; NONE otherwise.
REQ-017 Two 2-bit H_RES-deep line buffers and a 3x3 class window SHALL write and shift only on cycles with i_de=1; all other cycles hold.
REQ-018 Column counter SHALL increment on i_de and wrap H_RES-1 -> 0. Row counter SHALL increment on that wrap, saturate at V_RES-1, and clear on the i_vsync rising edge.
REQ-019 Window centre SHALL be the pixel one row above and one column left of the newest pixel.
REQ-020 Neighbours outside the frame SHALL be treated as NONE: left column if centre col = 0, right column if centre col = H_RES-1, top row if centre row = 0.
REQ-021 Decision: edge if centre STRONG, or centre WEAK and at least one valid 8-neighbour STRONG; otherwise no edge.
REQ-022 Decision SHALL be forced no-edge when the newest pixel is in row 0 or column 0.
REQ-023 Pipeline SHALL be 3 registered stages: window update, decision register, output register. The decision and output registers update every clock.
REQ-024 o_vsync/o_hsync/o_de SHALL equal i_vsync/i_hsync/i_de delayed exactly 3 clocks by a free-running shift register.
REQ-025 o_data SHALL be {WIDTH{1'b1}} for edge and 0 otherwise; it is meaningful only while o_de=1.
REQ-026 Edge counter SHALL increment on each cycle with o_de=1 and o_data nonzero, saturating at 2^CNT_W-1.
REQ-027 On the o_vsync rising edge: o_edge_cnt loads the counter, o_cnt_valid pulses 1 for one cycle, and the counter clears. An edge pixel in the same cycle SHALL count toward the new frame.
REQ-028 Row counter saturation SHALL make the bottom row a valid centre only if extra lines arrive; without them the last row and last column never appear as a centre, which is accepted.

Reset
REQ-029 rst=1 SHALL clear o_vsync, o_hsync, o_de, o_data, o_edge_cnt, o_cnt_valid, the delay lines, window, counters and edge counter to 0.
REQ-030 rst=1 SHALL set shadow thresholds to all ones. Line-buffer contents need no reset.
REQ-031 Reset asserted mid-frame SHALL take effect on the next clock. Outputs stay 0 until the first post-reset i_de propagates 3 clocks.

Verification
REQ-032 Uniform frame, i_data=200, high=100, low=50 -> after row 0 and column 0, every o_de pixel = 0xFF; o_edge_cnt = (H_RES-1)*(V_RES-1) = 25025 at next o_vsync rise.
REQ-033 All pixels 60 except one at 120 (row 10, col 10), high=100, low=50 -> o_data = 0xFF exactly at centres rows 9-11 x cols 9-11 (9 pixels); o_edge_cnt = 9.
REQ-034 Isolated WEAK 70 in a zero frame -> no edge; o_edge_cnt = 0.
REQ-035 STRONG pixel at col H_RES-1 with WEAK at col 0 of the next row -> col-0 centre not set by the wrapped neighbour.
REQ-036 i_th_high changed mid-frame -> classification unchanged until the next i_vsync rise; low=150 > high=100 -> weak set empty, only >= 100 marks edges.
REQ-037 Arbitrary sync pattern -> o_vsync/o_hsync/o_de equal inputs delayed exactly 3 clocks; rst pulse mid-line -> all outputs 0 next cycle.
